// File: rtl/alu_exec_unit_if.sv
// Handshake bundle between the EX-stage operand muxes, alu_exec_unit and the writeback path.
// Both sides are valid/ready: a transfer happens on a rising edge where valid && ready; valid must not depend on ready.
interface alu_exec_unit_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       alu_ctl;
  logic             sign;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;

  modport master (
    output in_valid, alu_ctl, sign, in_a, in_b, out_ready,
    input  in_ready, out_valid, result, zero, overflow
  );

  modport slave (
    input  in_valid, alu_ctl, sign, in_a, in_b, out_ready,
    output in_ready, out_valid, result, zero, overflow
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Multi-cycle EX-stage ALU with iterative one-bit-per-cycle shifter.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  alu_exec_unit_if.slave    bus,
  output logic [1:0]        state_dbg
);

  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_AND   = 5'b01000;
  localparam logic [4:0] OP_NOR   = 5'b01001;
  localparam logic [4:0] OP_XOR   = 5'b01010;
  localparam logic [4:0] OP_PASSA = 5'b01011;
  localparam logic [4:0] OP_OR    = 5'b01110;
  localparam logic [4:0] OP_SLL   = 5'b10000;
  localparam logic [4:0] OP_SRL   = 5'b10001;
  localparam logic [4:0] OP_SRA   = 5'b10011;
  localparam logic [4:0] OP_NEQ   = 5'b11001;
  localparam logic [4:0] OP_EQ    = 5'b11011;
  localparam logic [4:0] OP_LT    = 5'b11101;
  localparam logic [4:0] OP_LEZ   = 5'b11100;
  localparam logic [4:0] OP_LTZ   = 5'b11010;
  localparam logic [4:0] OP_GTZ   = 5'b11110;

`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST_SHIFT = 1'b1;
`else
  localparam bit FAST_SHIFT = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] res_q, sh_q, step;
  logic             ovf_q;
  logic [4:0]       cnt, sh_op;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] a, b, sum, diff, calc_res;
  logic             calc_ovf, lt, is_shift, start_iter, accept;

  assign a          = bus.in_a;
  assign b          = bus.in_b;
  assign shamt      = bus.in_a[4:0];
  assign is_shift   = (bus.alu_ctl == OP_SLL) || (bus.alu_ctl == OP_SRL) || (bus.alu_ctl == OP_SRA);
  assign start_iter = !FAST_SHIFT && is_shift && (shamt != 5'd0);
  assign accept     = bus.in_valid && bus.in_ready;

  // Single-cycle result; shifts here cover shamt==0 and the fast-shift build.
  always_comb begin
    sum      = a + b;
    diff     = a - b;
    lt       = bus.sign ? ($signed(a) < $signed(b)) : (a < b);
    calc_ovf = 1'b0;
    calc_res = sum;
    case (bus.alu_ctl)
      OP_SUB: begin
        calc_res = diff;
        calc_ovf = bus.sign && (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:   calc_res = a & b;
      OP_NOR:   calc_res = ~(a | b);
      OP_XOR:   calc_res = a ^ b;
      OP_PASSA: calc_res = a;
      OP_OR:    calc_res = a | b;
      OP_SLL:   calc_res = b << shamt;
      OP_SRL:   calc_res = b >> shamt;
      OP_SRA:   calc_res = $unsigned($signed(b) >>> shamt);
      OP_NEQ:   calc_res = {{(WIDTH-1){1'b0}}, (a != b)};
      OP_EQ:    calc_res = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_LT:    calc_res = {{(WIDTH-1){1'b0}}, lt};
      OP_LEZ:   calc_res = {{(WIDTH-1){1'b0}}, (a[WIDTH-1] || (a == '0))};
      OP_LTZ:   calc_res = {{(WIDTH-1){1'b0}}, a[WIDTH-1]};
      OP_GTZ:   calc_res = {{(WIDTH-1){1'b0}}, (!a[WIDTH-1] && (a != '0))};
      default: begin
        calc_res = sum;
        calc_ovf = bus.sign && (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
    endcase
  end

  always_comb begin
    case (sh_op)
      OP_SLL:  step = {sh_q[WIDTH-2:0], 1'b0};
      OP_SRL:  step = {1'b0, sh_q[WIDTH-1:1]};
      default: step = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.in_valid) state_nxt = start_iter ? S_SHIFT : S_DONE;
      S_SHIFT: if (cnt == 5'd1) state_nxt = S_DONE;
      S_DONE: begin
        if (bus.out_ready) begin
          if (bus.in_valid) state_nxt = start_iter ? S_SHIFT : S_DONE;
          else              state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == S_IDLE) || ((state == S_DONE) && bus.out_ready);
    bus.out_valid = (state == S_DONE);
    bus.result    = res_q;
    bus.zero      = (res_q == '0);
    bus.overflow  = ovf_q;
    state_dbg     = state;
  end

  // Result register only changes on accept or on the final shift step, keeping DONE outputs stable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_q <= '0;
      ovf_q <= 1'b0;
      sh_q  <= '0;
      cnt   <= 5'd0;
      sh_op <= 5'd0;
    end else if (accept) begin
      if (start_iter) begin
        sh_q  <= b;
        cnt   <= shamt;
        sh_op <= bus.alu_ctl;
      end else begin
        res_q <= calc_res;
        ovf_q <= calc_ovf;
      end
    end else if (state == S_SHIFT) begin
      sh_q <= step;
      cnt  <= cnt - 5'd1;
      if (cnt == 5'd1) begin
        res_q <= step;
        ovf_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized and directed bench for alu_exec_unit against a behavioural model using wide integer arithmetic.
// Honours ALU_FAST_SHIFT_EN for the expected shift latency.
module tb_alu_exec_unit;
  localparam int W = 32;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_AND   = 5'b01000;
  localparam logic [4:0] OP_NOR   = 5'b01001;
  localparam logic [4:0] OP_XOR   = 5'b01010;
  localparam logic [4:0] OP_PASSA = 5'b01011;
  localparam logic [4:0] OP_OR    = 5'b01110;
  localparam logic [4:0] OP_SLL   = 5'b10000;
  localparam logic [4:0] OP_SRL   = 5'b10001;
  localparam logic [4:0] OP_SRA   = 5'b10011;
  localparam logic [4:0] OP_NEQ   = 5'b11001;
  localparam logic [4:0] OP_EQ    = 5'b11011;
  localparam logic [4:0] OP_LT    = 5'b11101;
  localparam logic [4:0] OP_LEZ   = 5'b11100;
  localparam logic [4:0] OP_LTZ   = 5'b11010;
  localparam logic [4:0] OP_GTZ   = 5'b11110;

`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;

  alu_exec_unit_if #(.WIDTH(W)) bus ();

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_ovf_q[$];
  int           exp_lat_q[$];
  int           acc_q[$];
  bit           seen = 1'b0;
  logic [4:0]   codes [16] = '{OP_ADD, OP_SUB, OP_AND, OP_NOR, OP_XOR, OP_PASSA, OP_OR, OP_SLL,
                               OP_SRL, OP_SRA, OP_NEQ, OP_EQ, OP_LT, OP_LEZ, OP_LTZ, OP_GTZ};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W:0] ref_alu(input logic [4:0] c, input logic s,
                                         input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, ua, ub, exact;
    int     sh;
    logic [W-1:0] r;
    logic         o;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sh = int'(a[4:0]);
    o  = 1'b0;
    case (c)
      OP_SUB: begin
        exact = sa - sb;
        r = W'(exact);
        o = s && (exact > SMAX || exact < SMIN);
      end
      OP_AND:   r = a & b;
      OP_NOR:   r = ~(a | b);
      OP_XOR:   r = a ^ b;
      OP_PASSA: r = a;
      OP_OR:    r = a | b;
      OP_SLL:   r = W'(ub * (64'd1 << sh));
      OP_SRL:   r = W'(ub / (64'd1 << sh));
      OP_SRA:   r = W'(sb >>> sh);
      OP_NEQ:   r = W'(a != b);
      OP_EQ:    r = W'(a == b);
      OP_LT:    r = s ? W'(sa < sb) : W'(ua < ub);
      OP_LEZ:   r = W'(sa <= 0);
      OP_LTZ:   r = W'(sa < 0);
      OP_GTZ:   r = W'(sa > 0);
      default: begin
        exact = sa + sb;
        r = W'(exact);
        o = s && (exact > SMAX || exact < SMIN);
      end
    endcase
    return {o, r};
  endfunction

  function automatic int ref_lat(input logic [4:0] c, input logic [W-1:0] a);
    if ((c == OP_SLL || c == OP_SRL || c == OP_SRA) && a[4:0] != 5'd0 && !FAST)
      return int'(a[4:0]) + 1;
    return 1;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W:0] r;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        exp_q.delete(); exp_ovf_q.delete(); exp_lat_q.delete(); acc_q.delete();
        seen = 1'b0;
      end else begin
        if (exp_q.size() == 0) begin
          check("idle_valid", bus.out_valid, 1'b0);
        end else begin
          if (!bus.out_valid) check("busy_in_ready", bus.in_ready, 1'b0);
          else if (!seen) begin
            check("latency", cyc - acc_q[0], exp_lat_q[0]);
            seen = 1'b1;
          end
          if (bus.out_valid && bus.out_ready) begin
            check("result", bus.result, exp_q[0]);
            check("zero", bus.zero, exp_q[0] == '0);
            check("overflow", bus.overflow, exp_ovf_q[0]);
            void'(exp_q.pop_front()); void'(exp_ovf_q.pop_front());
            void'(exp_lat_q.pop_front()); void'(acc_q.pop_front());
            seen = 1'b0;
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          r = ref_alu(bus.alu_ctl, bus.sign, bus.in_a, bus.in_b);
          exp_q.push_back(r[W-1:0]);
          exp_ovf_q.push_back(r[W]);
          exp_lat_q.push_back(ref_lat(bus.alu_ctl, bus.in_a));
          acc_q.push_back(cyc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers an op, returns just after the accepting edge with inputs scrambled.
  task automatic send_op(input logic [4:0] c, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_valid = 1'b1;
    bus.alu_ctl  = c;
    bus.sign     = s;
    bus.in_a     = a;
    bus.in_b     = b;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        tick();
        bus.in_valid = 1'b0;
        bus.alu_ctl  = 5'($urandom);
        bus.sign     = 1'($urandom);
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
        return;
      end
    end
    check("accept_timeout", 1'b0, 1'b1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (bus.out_valid) return;
      tick();
    end
    check({tag, "_timeout"}, 1'b0, 1'b1);
  endtask

  task automatic retire();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit done;
    int lat;
    logic [4:0]   c;
    logic [W-1:0] a, b;
    bus.in_valid = 1'b0; bus.alu_ctl = 5'd0; bus.sign = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_result", bus.result, 32'h0);
    check("rst_zero", bus.zero, 1'b1);
    check("rst_overflow", bus.overflow, 1'b0);
    reset = 1'b1;
    tick();
    check("rst_in_ready", bus.in_ready, 1'b1);

    // ADD overflow, signed and unsigned
    send_op(OP_ADD, 1'b1, 32'h7FFF_FFFF, 32'h1);
    check("add_s_valid", bus.out_valid, 1'b1);
    check("add_s_res", bus.result, 32'h8000_0000);
    check("add_s_ovf", bus.overflow, 1'b1);
    retire();
    send_op(OP_ADD, 1'b0, 32'h7FFF_FFFF, 32'h1);
    check("add_u_res", bus.result, 32'h8000_0000);
    check("add_u_ovf", bus.overflow, 1'b0);
    retire();

    // LT signed vs unsigned
    send_op(OP_LT, 1'b1, 32'hFFFF_FFFF, 32'h1);
    check("lt_s_res", bus.result, 32'h1);
    retire();
    send_op(OP_LT, 1'b0, 32'hFFFF_FFFF, 32'h1);
    check("lt_u_res", bus.result, 32'h0);
    check("lt_u_zero", bus.zero, 1'b1);
    retire();

    // SRA by 4
    send_op(OP_SRA, 1'b0, 32'd4, 32'h8000_0000);
    lat = FAST ? 1 : 5;
    for (int k = 1; k < lat; k++) begin
      check("sra_busy_valid", bus.out_valid, 1'b0);
      check("sra_busy_ready", bus.in_ready, 1'b0);
      tick();
    end
    check("sra_valid", bus.out_valid, 1'b1);
    check("sra_res", bus.result, 32'hF800_0000);
    retire();

    // Backpressure hold then retire-and-accept in the same cycle
    send_op(OP_ADD, 1'b0, 32'd5, 32'd6);
    repeat (3) begin
      check("hold_valid", bus.out_valid, 1'b1);
      check("hold_res", bus.result, 32'd11);
      check("hold_ready", bus.in_ready, 1'b0);
      tick();
    end
    bus.out_ready = 1'b1;
    send_op(OP_XOR, 1'b0, 32'hF0F0_F0F0, 32'hFFFF_0000);
    bus.out_ready = 1'b0;
    check("xor_valid", bus.out_valid, 1'b1);
    check("xor_res", bus.result, 32'h0F0F_F0F0);
    retire();

    // Back-to-back single-cycle ops
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_op(OP_SUB, 1'b1, 32'h8000_0000 + k, 32'd1);
      check("b2b_ready", bus.in_ready, 1'b1);
      check("b2b_valid", bus.out_valid, 1'b1);
    end
    tick();
    bus.out_ready = 1'b0;

    // Reset in the middle of a long shift
    send_op(OP_SLL, 1'b0, 32'd31, 32'h1);
    repeat (9) tick();
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", bus.out_valid, 1'b0);
    check("mid_rst_result", bus.result, 32'h0);
    check("mid_rst_zero", bus.zero, 1'b1);
    repeat (2) tick();
    #3 reset = 1'b1;
    tick();
    check("mid_rst_ready", bus.in_ready, 1'b1);
    send_op(OP_SLL, 1'b0, 32'd3, 32'h1);
    wait_valid("post_rst");
    check("post_rst_res", bus.result, 32'h8);
    retire();

    // Randomized traffic with random backpressure
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          c = ($urandom_range(0, 9) == 0) ? 5'($urandom) : codes[$urandom_range(0, 15)];
          a = $urandom;
          b = $urandom;
          if ($urandom_range(0, 1) == 0) a[4:0] = 5'($urandom_range(0, 3));
          if ($urandom_range(0, 7) == 0) b = a;
          if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
          if ($urandom_range(0, 9) == 0) a = 32'h0;
          send_op(c, 1'($urandom_range(0, 1)), a, b);
          if ($urandom_range(0, 3) == 0) tick();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join

    bus.out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !bus.out_valid) break;
      tick();
    end
    check("drain_empty", exp_q.size(), 0);
    bus.out_ready = 1'b0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
